// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity codes,
// FSM state encoding, frame length and parity helpers.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic int frame_len(input int clks_per_bit, input int data_bits,
                                     input int parity, input int stop_bits);
        return clks_per_bit * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
    endfunction

    // Only the low data_bits bits take part in the parity.
    function automatic logic calc_parity(input logic [7:0] data, input int data_bits,
                                         input int parity);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < data_bits) begin
                acc = acc ^ data[i];
            end
        end
        return (parity == PAR_ODD) ? ~acc : acc;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; full/empty are registered so the
// upstream ready never depends combinationally on the same-cycle push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_nxt_s;
    logic [PW-1:0]    rd_ptr_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && !full_r;
    assign pop_ok_s  = pop && !empty_r;

    // Next pointer values for the registered status flags.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push_ok_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_ok_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            full_r   <= ((wr_ptr_nxt_s - rd_ptr_nxt_s) == PW'(DEPTH));
            empty_r  <= (wr_ptr_nxt_s == rd_ptr_nxt_s);
        end
    end

    // Storage array; contents are discarded by resetting the pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r[AW-1:0]];
    assign full  = full_r;
    assign empty = empty_r;
    assign level = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with an input FIFO; frames are sent
// back-to-back, LSB first, with optional parity and one or two stop bits.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int FRAME_LEN = frame_len(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS);
    localparam int FCW       = $clog2(FRAME_LEN);
    localparam int CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int IDX_W     = $clog2(DATA_BITS);

    tx_state_e              state_r, state_nxt;
    logic [CNT_W-1:0]       cnt_r, cnt_nxt;
    logic [IDX_W-1:0]       bit_idx_r, bit_idx_nxt;
    logic [DATA_BITS-1:0]   shift_r, shift_nxt;
    logic                   par_r, par_nxt;
    logic [FCW-1:0]         frame_cnt_r, frame_cnt_nxt;
    logic                   txd_r, txd_nxt;
    logic                   busy_r, busy_nxt;
    logic                   done_r, done_nxt;

    logic                   fifo_push_s;
    logic                   fifo_pop_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [DATA_BITS-1:0]   fifo_rdata_s;
    logic                   bit_end_s;
    logic                   last_cyc_s;
    logic                   start_frame_s;

    assign fifo_push_s = tx_valid && !fifo_full_s;
    assign bit_end_s   = (cnt_r == CNT_W'(CLKS_PER_BIT - 1));
    assign last_cyc_s  = (frame_cnt_r == FCW'(FRAME_LEN - 1));

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_s),
        .wdata (tx_data),
        .pop   (fifo_pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    // Next-state, datapath and output logic of the transmit FSM.
    always_comb begin
        state_nxt     = state_r;
        cnt_nxt       = cnt_r;
        bit_idx_nxt   = bit_idx_r;
        shift_nxt     = shift_r;
        par_nxt       = par_r;
        frame_cnt_nxt = frame_cnt_r;
        txd_nxt       = txd_r;
        busy_nxt      = busy_r;
        start_frame_s = 1'b0;
        fifo_pop_s    = 1'b0;

        if (state_r != ST_IDLE) begin
            cnt_nxt       = bit_end_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
            frame_cnt_nxt = frame_cnt_r + FCW'(1);
        end else begin
            cnt_nxt       = {CNT_W{1'b0}};
            frame_cnt_nxt = {FCW{1'b0}};
        end

        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    start_frame_s = 1'b1;
                end else begin
                    txd_nxt  = 1'b1;
                    busy_nxt = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_nxt   = ST_DATA;
                    bit_idx_nxt = {IDX_W{1'b0}};
                    txd_nxt     = shift_r[0];
                    shift_nxt   = {1'b0, shift_r[DATA_BITS-1:1]};
                end else begin
                    txd_nxt = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    if (bit_idx_r == IDX_W'(DATA_BITS - 1)) begin
                        if (PARITY != PAR_NONE) begin
                            state_nxt = ST_PARITY;
                            txd_nxt   = par_r;
                        end else begin
                            state_nxt = ST_STOP;
                            txd_nxt   = 1'b1;
                        end
                    end else begin
                        bit_idx_nxt = bit_idx_r + IDX_W'(1);
                        txd_nxt     = shift_r[0];
                        shift_nxt   = {1'b0, shift_r[DATA_BITS-1:1]};
                    end
                end else begin
                    txd_nxt = txd_r;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_nxt = ST_STOP;
                    txd_nxt   = 1'b1;
                end else begin
                    txd_nxt = txd_r;
                end
            end
            ST_STOP: begin
                // The frame counter marks the end of the last stop bit.
                if (last_cyc_s) begin
                    if (!fifo_empty_s) begin
                        start_frame_s = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        busy_nxt  = 1'b0;
                        txd_nxt   = 1'b1;
                    end
                end else begin
                    txd_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                txd_nxt   = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase

        if (start_frame_s) begin
            fifo_pop_s    = 1'b1;
            state_nxt     = ST_START;
            cnt_nxt       = {CNT_W{1'b0}};
            frame_cnt_nxt = {FCW{1'b0}};
            bit_idx_nxt   = {IDX_W{1'b0}};
            shift_nxt     = fifo_rdata_s;
            par_nxt       = calc_parity(8'(fifo_rdata_s), DATA_BITS, PARITY);
            txd_nxt       = 1'b0;
            busy_nxt      = 1'b1;
        end else begin
            fifo_pop_s    = 1'b0;
        end

        done_nxt = (state_nxt == ST_STOP) && (frame_cnt_nxt == FCW'(FRAME_LEN - 1));
    end

    // State, datapath and output registers; reset forces the line idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            bit_idx_r   <= {IDX_W{1'b0}};
            shift_r     <= {DATA_BITS{1'b0}};
            par_r       <= 1'b0;
            frame_cnt_r <= {FCW{1'b0}};
            txd_r       <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            cnt_r       <= cnt_nxt;
            bit_idx_r   <= bit_idx_nxt;
            shift_r     <= shift_nxt;
            par_r       <= par_nxt;
            frame_cnt_r <= frame_cnt_nxt;
            txd_r       <= txd_nxt;
            busy_r      <= busy_nxt;
            done_r      <= done_nxt;
        end
    end

    assign tx_ready = !fifo_full_s;
    assign txd      = txd_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Scoreboard bench: four transmitter configurations; accepted bytes are queued
// and per-instance serial monitors decode each frame cycle by cycle.
module tb_uart_tx_fifo_param;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0][7:0]  tx_data_w;
    logic [3:0]       tx_valid_w;
    logic [3:0]       tx_ready_w;
    logic [3:0]       txd_w;
    logic [3:0]       busy_w;
    logic [3:0]       done_w;
    logic [3:0][2:0]  level_w;

    int cpb_p [4] = '{16, 16, 16, 4};
    int db_p  [4] = '{8, 8, 8, 7};
    int par_p [4] = '{0, 2, 1, 0};
    int len_p [4] = '{160, 176, 176, 40};

    logic [7:0] exp_q [4][$];
    int         starts_q [$];
    int         done_cnt [4] = '{0, 0, 0, 0};
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic       obs_en = 1'b0;
    int         lvl_max = 0;
    int         rdy_err = 0;
    logic       saw_full = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .tx_data(tx_data_w[0]), .tx_valid(tx_valid_w[0]), .tx_ready(tx_ready_w[0]),
        .txd(txd_w[0]), .busy(busy_w[0]), .done(done_w[0]), .fifo_level(level_w[0]));
    uart_tx_fifo_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .tx_data(tx_data_w[1]), .tx_valid(tx_valid_w[1]), .tx_ready(tx_ready_w[1]),
        .txd(txd_w[1]), .busy(busy_w[1]), .done(done_w[1]), .fifo_level(level_w[1]));
    uart_tx_fifo_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .tx_data(tx_data_w[2]), .tx_valid(tx_valid_w[2]), .tx_ready(tx_ready_w[2]),
        .txd(txd_w[2]), .busy(busy_w[2]), .done(done_w[2]), .fifo_level(level_w[2]));
    uart_tx_fifo_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .tx_data(tx_data_w[3][6:0]), .tx_valid(tx_valid_w[3]), .tx_ready(tx_ready_w[3]),
        .txd(txd_w[3]), .busy(busy_w[3]), .done(done_w[3]), .fifo_level(level_w[3]));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (done_w[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
        end
    end

    always @(negedge clk) begin
        if (obs_en) begin
            if (int'(level_w[0]) > lvl_max) lvl_max <= int'(level_w[0]);
            if (tx_ready_w[0] !== (level_w[0] != 3'd4)) rdy_err <= rdy_err + 1;
            if (level_w[0] == 3'd4) saw_full <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Expected line level for bit slot pos of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int pos, input int k);
        logic x;
        if (pos == 0) return 1'b0;
        if (pos <= db_p[k]) return d[pos-1];
        if (par_p[k] != 0 && pos == db_p[k] + 1) begin
            x = 1'b0;
            for (int i = 0; i < db_p[k]; i++) x = x ^ d[i];
            return (par_p[k] == 1) ? ~x : x;
        end
        return 1'b1;
    endfunction

    task automatic mon(input int k);
        logic [7:0] d;
        int errs, derrs, first_c;
        logic aborted;
        forever begin
            @(negedge clk);
            if (!rst && txd_w[k] == 1'b0) begin
                total++;
                if (exp_q[k].size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_frame dut%0d: got a start bit, required no frame", k);
                    d = 8'h00;
                end else begin
                    d = exp_q[k].pop_front();
                end
                if (k == 0) starts_q.push_back(cyc);
                errs = 0; derrs = 0; first_c = 0; aborted = 1'b0;
                for (int c = 1; c <= len_p[k]; c++) begin
                    if (c > 1) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (txd_w[k] !== exp_bit(d, (c - 1) / cpb_p[k], k) || busy_w[k] !== 1'b1) begin
                        if (errs == 0) first_c = c;
                        errs++;
                    end
                    if (done_w[k] !== (c == len_p[k])) derrs++;
                end
                if (aborted) begin
                    exp_q[k].delete();
                end else begin
                    total += 2;
                    if (errs != 0) begin
                        bad++;
                        $display("FAIL frame_bits dut%0d byte %h: got %0d wrong cycles (first %0d), required 0", k, d, errs, first_c);
                    end
                    if (derrs != 0) begin
                        bad++;
                        $display("FAIL done_pulse dut%0d byte %h: got %0d wrong cycles, required 0", k, d, derrs);
                    end
                end
            end
        end
    endtask

    task automatic push(input int k, input logic [7:0] d);
        int g;
        tx_data_w[k]  = d;
        tx_valid_w[k] = 1'b1;
        g = 0;
        while (!tx_ready_w[k] && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) begin
            total++; bad++;
            $display("FAIL push_timeout dut%0d: got tx_ready=0, required 1", k);
        end else begin
            exp_q[k].push_back(d);
        end
        @(negedge clk);
        tx_valid_w[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((busy_w[k] || level_w[k] != 3'd0) && g < 4000);
        chk("idle_timeout", (g >= 4000) ? 32'd1 : 32'd0, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int quiet;
        rst = 1'b1;
        tx_valid_w = 4'b0000;
        tx_data_w = '0;
        fork
            mon(0); mon(1); mon(2); mon(3);
        join_none
        repeat (3) @(negedge clk);
        chk("rst_txd", txd_w[0], 1);
        chk("rst_busy", busy_w[0], 0);
        chk("rst_done", done_w[0], 0);
        chk("rst_level", level_w[0], 0);
        chk("rst_ready", tx_ready_w[0], 1);
        chk("rst_txd_u3", txd_w[3], 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 0x55: one cycle latency, done on cycle 160, then idle.
        d0 = done_cnt[0];
        push(0, 8'h55);
        chk("lat_level", level_w[0], 1);
        chk("lat_txd_high", txd_w[0], 1);
        @(negedge clk);
        chk("lat_txd_low", txd_w[0], 0);
        chk("lat_busy", busy_w[0], 1);
        chk("lat_level_pop", level_w[0], 0);
        repeat (159) @(negedge clk);
        chk("done_at_160", done_w[0], 1);
        @(negedge clk);
        chk("after_busy", busy_w[0], 0);
        chk("after_txd", txd_w[0], 1);
        chk("after_done", done_w[0], 0);
        chk("done_cnt_1", done_cnt[0] - d0, 1);

        // Parity of 0x07: even -> 1, odd -> 0; 176-cycle frames.
        push(1, 8'h07);
        repeat (152) @(negedge clk);
        chk("even_parity", txd_w[1], 1);
        repeat (24) @(negedge clk);
        chk("even_done_176", done_w[1], 1);
        wait_idle(1);
        push(2, 8'h07);
        repeat (152) @(negedge clk);
        chk("odd_parity", txd_w[2], 0);
        repeat (24) @(negedge clk);
        chk("odd_done_176", done_w[2], 1);
        wait_idle(2);

        // Burst: fill the FIFO, hold a write while full, back-to-back frames.
        starts_q.delete();
        d0 = done_cnt[0];
        obs_en = 1'b1;
        push(0, 8'h11);
        chk("burst_level_1", level_w[0], 1);
        push(0, 8'h22);
        chk("pushpop_level", level_w[0], 1);
        push(0, 8'h33);
        push(0, 8'h44);
        push(0, 8'h55);
        chk("full_level", level_w[0], 4);
        chk("full_ready", tx_ready_w[0], 0);
        push(0, 8'h66);
        wait_idle(0);
        obs_en = 1'b0;
        chk("burst_done_cnt", done_cnt[0] - d0, 6);
        chk("burst_lvl_max", lvl_max, 4);
        chk("burst_ready_vs_full", rdy_err, 0);
        chk("burst_saw_full", saw_full, 1);
        chk("burst_frames", starts_q.size(), 6);
        for (int i = 0; i + 1 < starts_q.size(); i++) begin
            chk("frame_gap", starts_q[i+1] - starts_q[i], 160);
        end

        // Reset in the middle of 0xA3 with two more bytes queued.
        push(0, 8'hA3);
        push(0, 8'hB1);
        push(0, 8'hC2);
        repeat (40) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_txd", txd_w[0], 1);
        chk("mid_rst_busy", busy_w[0], 0);
        chk("mid_rst_level", level_w[0], 0);
        chk("mid_rst_ready", tx_ready_w[0], 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q[0].delete();
        d0 = done_cnt[0];
        quiet = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy_w[0] !== 1'b0 || txd_w[0] !== 1'b1) quiet++;
        end
        chk("post_rst_quiet", quiet, 0);
        chk("post_rst_done", done_cnt[0] - d0, 0);
        push(0, 8'h5A);
        wait_idle(0);

        // 7N2 at 4 clocks per bit, 0x7F: 40-cycle frame.
        push(3, 8'h7F);
        @(negedge clk);
        chk("u3_start", txd_w[3], 0);
        repeat (4) @(negedge clk);
        chk("u3_data0", txd_w[3], 1);
        repeat (28) @(negedge clk);
        chk("u3_stop1", txd_w[3], 1);
        repeat (7) @(negedge clk);
        chk("u3_done_40", done_w[3], 1);
        @(negedge clk);
        chk("u3_idle", busy_w[3], 0);
        wait_idle(3);

        repeat (5) @(negedge clk);
        for (int k = 0; k < 4; k++) chk("queue_drained", exp_q[k].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
